// File: rtl/udp_rx_packer_if.sv
// Bundle of the byte-stream input, the packed-frame handshake and the
// drop counter for udp_rx_packer.
// The master side feeds bytes and consumes frames; the slave side is the packer.
interface udp_rx_packer_if #(
    parameter int MAX_BYTES = 120,
    parameter int CNT_W     = 16
) ();
    logic                   udp_rec_data_valid;
    logic [7:0]             udp_rec_rdata;
    logic                   pkt_valid;
    logic                   pkt_ready;
    logic [MAX_BYTES*8-1:0] pkt_data;
    logic [CNT_W-1:0]       pkt_length;
    logic                   pkt_trunc;
    logic [CNT_W-1:0]       drop_cnt;

    modport master (
        output udp_rec_data_valid, udp_rec_rdata, pkt_ready,
        input  pkt_valid, pkt_data, pkt_length, pkt_trunc, drop_cnt
    );

    modport slave (
        input  udp_rec_data_valid, udp_rec_rdata, pkt_ready,
        output pkt_valid, pkt_data, pkt_length, pkt_trunc, drop_cnt
    );
endinterface

// File: rtl/udp_rx_packer.sv
// Packs the UDP receive byte stream into one MSB-first wide word plus a
// byte count, and offers it to user logic over a valid/ready handshake.
// A frame that arrives while a packed frame is still held is discarded
// whole and counted in drop_cnt.
module udp_rx_packer #(
    parameter int MAX_BYTES = 120,
    parameter int CNT_W     = 16
) (
    input  logic           rgmii_clk,
    input  logic           rst,
    udp_rx_packer_if.slave bus
);
    localparam int DW = MAX_BYTES * 8;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    typedef enum logic [1:0] {IDLE, FILL, HOLD, DROP} state_t;

    state_t           state_q, state_d;
    logic             wait_low_q, wait_low_d;
    logic [DW-1:0]    buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trunc_q, trunc_d;
    logic             pkt_valid_q, pkt_valid_d;
    logic [DW-1:0]    pkt_data_q, pkt_data_d;
    logic [CNT_W-1:0] pkt_length_q, pkt_length_d;
    logic             pkt_trunc_q, pkt_trunc_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == {CNT_W{1'b1}}) ? x : x + CNT_W'(1);
    endfunction

    // Byte index 0 lands in the top byte lane, later bytes descend.
    function automatic logic [DW-1:0] put_byte(input logic [DW-1:0]    b,
                                               input logic [CNT_W-1:0] idx,
                                               input logic [7:0]       d);
        logic [DW-1:0] r;
        r = b;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (CNT_W'(i) == idx) r[(MAX_BYTES-1-i)*8 +: 8] = d;
        end
        return r;
    endfunction

    // Next-state and datapath updates for the packing FSM.
    always_comb begin
        state_d      = state_q;
        wait_low_d   = wait_low_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        trunc_d      = trunc_q;
        pkt_valid_d  = pkt_valid_q;
        pkt_data_d   = pkt_data_q;
        pkt_length_d = pkt_length_q;
        pkt_trunc_d  = pkt_trunc_q;
        drop_cnt_d   = drop_cnt_q;

        // A run that was already active when reset released is never
        // packed; arm only once the stream has been seen low.
        if (!bus.udp_rec_data_valid) wait_low_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.udp_rec_data_valid && !wait_low_q) begin
                    buf_d   = put_byte('0, '0, bus.udp_rec_rdata);
                    cnt_d   = CNT_W'(1);
                    trunc_d = 1'b0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (bus.udp_rec_data_valid) begin
                    if (cnt_q < MAX_CNT) buf_d = put_byte(buf_q, cnt_q, bus.udp_rec_rdata);
                    else                 trunc_d = 1'b1;
                    cnt_d = sat_inc(cnt_q);
                end else begin
                    pkt_valid_d  = 1'b1;
                    pkt_data_d   = buf_q;
                    pkt_length_d = cnt_q;
                    pkt_trunc_d  = trunc_q;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (bus.pkt_ready) begin
                    pkt_valid_d = 1'b0;
                    if (bus.udp_rec_data_valid) begin
                        // Held frame leaves this cycle, so the new frame may
                        // start filling immediately.
                        buf_d   = put_byte('0, '0, bus.udp_rec_rdata);
                        cnt_d   = CNT_W'(1);
                        trunc_d = 1'b0;
                        state_d = FILL;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.udp_rec_data_valid) begin
                    drop_cnt_d = sat_inc(drop_cnt_q);
                    state_d    = DROP;
                end
            end
            DROP: begin
                if (pkt_valid_q && bus.pkt_ready) pkt_valid_d = 1'b0;
                if (!bus.udp_rec_data_valid) begin
                    state_d = (pkt_valid_q && !bus.pkt_ready) ? HOLD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and output registers, cleared by reset.
    always_ff @(posedge rgmii_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wait_low_q   <= bus.udp_rec_data_valid;
            cnt_q        <= '0;
            trunc_q      <= 1'b0;
            pkt_valid_q  <= 1'b0;
            pkt_data_q   <= '0;
            pkt_length_q <= '0;
            pkt_trunc_q  <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wait_low_q   <= wait_low_d;
            cnt_q        <= cnt_d;
            trunc_q      <= trunc_d;
            pkt_valid_q  <= pkt_valid_d;
            pkt_data_q   <= pkt_data_d;
            pkt_length_q <= pkt_length_d;
            pkt_trunc_q  <= pkt_trunc_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Fill buffer; it is cleared whenever a frame starts, so no reset needed.
    always_ff @(posedge rgmii_clk) begin
        buf_q <= buf_d;
    end

    assign bus.pkt_valid  = pkt_valid_q;
    assign bus.pkt_data   = pkt_data_q;
    assign bus.pkt_length = pkt_length_q;
    assign bus.pkt_trunc  = pkt_trunc_q;
    assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_udp_rx_packer.sv
// Directed testbench for udp_rx_packer: reset, short/full/oversize frames,
// drop while held, same-cycle accept-and-start, back-to-back, mid-frame reset.
module tb_udp_rx_packer;
    localparam int MAX_BYTES = 120;
    localparam int CNT_W     = 16;
    localparam int DW        = MAX_BYTES * 8;

    logic rgmii_clk = 1'b0;
    logic rst;

    udp_rx_packer_if #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) bus ();

    udp_rx_packer #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
        .rgmii_clk (rgmii_clk),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 rgmii_clk = ~rgmii_clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic tick();
        @(posedge rgmii_clk);
        #1;
    endtask

    task automatic send_bytes(input int n, input logic [7:0] start, input logic [7:0] step);
        for (int i = 0; i < n; i++) begin
            bus.udp_rec_data_valid = 1'b1;
            bus.udp_rec_rdata      = start + 8'(i) * step;
            tick();
        end
    endtask

    task automatic end_frame();
        bus.udp_rec_data_valid = 1'b0;
        bus.udp_rec_rdata      = 8'h00;
        tick();
    endtask

    function automatic logic [DW-1:0] exp_data(input int n, input logic [7:0] start, input logic [7:0] step);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < n && i < MAX_BYTES; i++) r[(MAX_BYTES-1-i)*8 +: 8] = start + 8'(i) * step;
        return r;
    endfunction

    function automatic int first_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
        for (int i = 0; i < MAX_BYTES; i++)
            if (a[(MAX_BYTES-1-i)*8 +: 8] !== b[(MAX_BYTES-1-i)*8 +: 8]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.udp_rec_data_valid = 1'b0;
        bus.udp_rec_rdata = 8'h00;
        bus.pkt_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        total_cnt++;
        if (bus.pkt_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.pkt_valid); else pass_cnt++;
        total_cnt++;
        if (bus.pkt_data !== '0) $display("FAIL reset_data: nonzero, top %h want 0", bus.pkt_data[DW-1 -: 32]); else pass_cnt++;
        total_cnt++;
        if (bus.pkt_length !== 16'd0) $display("FAIL reset_length: got %0d want 0", bus.pkt_length); else pass_cnt++;
        total_cnt++;
        if (bus.pkt_trunc !== 1'b0) $display("FAIL reset_trunc: got %0b want 0", bus.pkt_trunc); else pass_cnt++;
        total_cnt++;
        if (bus.drop_cnt !== 16'd0) $display("FAIL reset_drop: got %0d want 0", bus.drop_cnt); else pass_cnt++;
    endtask

    task automatic test_four_byte();
        logic [DW-1:0] exp;
        exp = '0;
        exp[DW-1 -: 32] = 32'h11223344;
        bus.pkt_ready = 1'b1;
        send_bytes(4, 8'h11, 8'h11);
        total_cnt++;
        if (bus.pkt_valid !== 1'b0) $display("FAIL four_early_valid: got %0b want 0", bus.pkt_valid); else pass_cnt++;
        end_frame();
        total_cnt++;
        if (bus.pkt_valid !== 1'b1) $display("FAIL four_valid: got %0b want 1", bus.pkt_valid); else pass_cnt++;
        total_cnt++;
        if (bus.pkt_data !== exp) $display("FAIL four_data: byte %0d top %h want %h", first_diff(bus.pkt_data, exp), bus.pkt_data[DW-1 -: 32], 32'h11223344); else pass_cnt++;
        total_cnt++;
        if (bus.pkt_length !== 16'd4) $display("FAIL four_length: got %0d want 4", bus.pkt_length); else pass_cnt++;
        total_cnt++;
        if (bus.pkt_trunc !== 1'b0) $display("FAIL four_trunc: got %0b want 0", bus.pkt_trunc); else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.pkt_valid !== 1'b0) $display("FAIL four_valid_drop: got %0b want 0", bus.pkt_valid); else pass_cnt++;
    endtask

    task automatic test_full_frame();
        logic [DW-1:0] exp;
        exp = exp_data(120, 8'h00, 8'h01);
        send_bytes(120, 8'h00, 8'h01);
        end_frame();
        total_cnt++;
        if (bus.pkt_valid !== 1'b1) $display("FAIL full_valid: got %0b want 1", bus.pkt_valid); else pass_cnt++;
        total_cnt++;
        if (bus.pkt_data[959:952] !== 8'h00) $display("FAIL full_first: got %h want 00", bus.pkt_data[959:952]); else pass_cnt++;
        total_cnt++;
        if (bus.pkt_data[7:0] !== 8'h77) $display("FAIL full_last: got %h want 77", bus.pkt_data[7:0]); else pass_cnt++;
        total_cnt++;
        if (first_diff(bus.pkt_data, exp) != -1) $display("FAIL full_data: byte %0d differs", first_diff(bus.pkt_data, exp)); else pass_cnt++;
        total_cnt++;
        if (bus.pkt_length !== 16'd120) $display("FAIL full_length: got %0d want 120", bus.pkt_length); else pass_cnt++;
        total_cnt++;
        if (bus.pkt_trunc !== 1'b0) $display("FAIL full_trunc: got %0b want 0", bus.pkt_trunc); else pass_cnt++;
        tick();
    endtask

    task automatic test_oversize();
        logic [DW-1:0] exp;
        exp = exp_data(120, 8'h00, 8'h01);
        send_bytes(130, 8'h00, 8'h01);
        end_frame();
        total_cnt++;
        if (bus.pkt_valid !== 1'b1) $display("FAIL over_valid: got %0b want 1", bus.pkt_valid); else pass_cnt++;
        total_cnt++;
        if (bus.pkt_data[7:0] !== 8'h77) $display("FAIL over_last: got %h want 77", bus.pkt_data[7:0]); else pass_cnt++;
        total_cnt++;
        if (first_diff(bus.pkt_data, exp) != -1) $display("FAIL over_data: byte %0d differs", first_diff(bus.pkt_data, exp)); else pass_cnt++;
        total_cnt++;
        if (bus.pkt_length !== 16'd130) $display("FAIL over_length: got %0d want 130", bus.pkt_length); else pass_cnt++;
        total_cnt++;
        if (bus.pkt_trunc !== 1'b1) $display("FAIL over_trunc: got %0b want 1", bus.pkt_trunc); else pass_cnt++;
        tick();
    endtask

    task automatic test_drop();
        bus.pkt_ready = 1'b0;
        send_bytes(2, 8'hA0, 8'h01);
        end_frame();
        total_cnt++;
        if (bus.pkt_valid !== 1'b1) $display("FAIL drop_a_valid: got %0b want 1", bus.pkt_valid); else pass_cnt++;
        send_bytes(5, 8'hB0, 8'h01);
        end_frame();
        total_cnt++;
        if (bus.pkt_valid !== 1'b1) $display("FAIL drop_hold_valid: got %0b want 1", bus.pkt_valid); else pass_cnt++;
        total_cnt++;
        if (bus.pkt_length !== 16'd2) $display("FAIL drop_length: got %0d want 2", bus.pkt_length); else pass_cnt++;
        total_cnt++;
        if (bus.pkt_data[DW-1 -: 24] !== 24'hA0A100) $display("FAIL drop_data: got %h want a0a100", bus.pkt_data[DW-1 -: 24]); else pass_cnt++;
        total_cnt++;
        if (bus.drop_cnt !== 16'd1) $display("FAIL drop_cnt: got %0d want 1", bus.drop_cnt); else pass_cnt++;
        bus.pkt_ready = 1'b1;
        tick();
        total_cnt++;
        if (bus.pkt_valid !== 1'b0) $display("FAIL drop_accept: got %0b want 0", bus.pkt_valid); else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (bus.pkt_valid !== 1'b0) $display("FAIL drop_b_presented: got %0b want 0", bus.pkt_valid); else pass_cnt++;
    endtask

    task automatic test_accept_and_start();
        bus.pkt_ready = 1'b0;
        send_bytes(3, 8'h01, 8'h01);
        end_frame();
        total_cnt++;
        if (bus.pkt_valid !== 1'b1) $display("FAIL same_held_valid: got %0b want 1", bus.pkt_valid); else pass_cnt++;
        bus.pkt_ready = 1'b1;
        bus.udp_rec_data_valid = 1'b1;
        bus.udp_rec_rdata = 8'hAB;
        tick();
        total_cnt++;
        if (bus.pkt_valid !== 1'b0) $display("FAIL same_accept: got %0b want 0", bus.pkt_valid); else pass_cnt++;
        send_bytes(2, 8'hAC, 8'h01);
        end_frame();
        total_cnt++;
        if (bus.pkt_valid !== 1'b1) $display("FAIL same_c_valid: got %0b want 1", bus.pkt_valid); else pass_cnt++;
        total_cnt++;
        if (bus.pkt_data[DW-1 -: 32] !== 32'hABACAD00) $display("FAIL same_c_data: got %h want abacad00", bus.pkt_data[DW-1 -: 32]); else pass_cnt++;
        total_cnt++;
        if (bus.pkt_length !== 16'd3) $display("FAIL same_c_length: got %0d want 3", bus.pkt_length); else pass_cnt++;
        total_cnt++;
        if (bus.drop_cnt !== 16'd1) $display("FAIL same_drop_cnt: got %0d want 1", bus.drop_cnt); else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        bus.pkt_ready = 1'b1;
        send_bytes(2, 8'h10, 8'h10);
        end_frame();
        total_cnt++;
        if (bus.pkt_valid !== 1'b1 || bus.pkt_data[DW-1 -: 16] !== 16'h1020)
            $display("FAIL b2b_e: valid %0b data %h want 1 1020", bus.pkt_valid, bus.pkt_data[DW-1 -: 16]);
        else pass_cnt++;
        send_bytes(2, 8'h30, 8'h10);
        end_frame();
        total_cnt++;
        if (bus.pkt_valid !== 1'b1 || bus.pkt_data[DW-1 -: 24] !== 24'h304000)
            $display("FAIL b2b_f: valid %0b data %h want 1 304000", bus.pkt_valid, bus.pkt_data[DW-1 -: 24]);
        else pass_cnt++;
        total_cnt++;
        if (bus.pkt_length !== 16'd2) $display("FAIL b2b_f_length: got %0d want 2", bus.pkt_length); else pass_cnt++;
        tick();
    endtask

    task automatic test_mid_reset();
        bus.pkt_ready = 1'b1;
        send_bytes(4, 8'h60, 8'h01);
        rst = 1'b1;
        bus.udp_rec_data_valid = 1'b1;
        bus.udp_rec_rdata = 8'h64;
        tick();
        rst = 1'b0;
        total_cnt++;
        if (bus.pkt_valid !== 1'b0 || bus.pkt_length !== 16'd0 || bus.drop_cnt !== 16'd0 || bus.pkt_data !== '0)
            $display("FAIL rst_clear: valid %0b len %0d drop %0d want 0 0 0", bus.pkt_valid, bus.pkt_length, bus.drop_cnt);
        else pass_cnt++;
        send_bytes(5, 8'h65, 8'h01);
        end_frame();
        total_cnt++;
        if (bus.pkt_valid !== 1'b0) $display("FAIL rst_partial_valid: got %0b want 0", bus.pkt_valid); else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.pkt_valid !== 1'b0 || bus.drop_cnt !== 16'd0)
            $display("FAIL rst_partial_late: valid %0b drop %0d want 0 0", bus.pkt_valid, bus.drop_cnt);
        else pass_cnt++;
        send_bytes(3, 8'h55, 8'h11);
        end_frame();
        total_cnt++;
        if (bus.pkt_valid !== 1'b1) $display("FAIL rst_next_valid: got %0b want 1", bus.pkt_valid); else pass_cnt++;
        total_cnt++;
        if (bus.pkt_data[DW-1 -: 32] !== 32'h55667700) $display("FAIL rst_next_data: got %h want 55667700", bus.pkt_data[DW-1 -: 32]); else pass_cnt++;
        total_cnt++;
        if (bus.pkt_length !== 16'd3) $display("FAIL rst_next_length: got %0d want 3", bus.pkt_length); else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_four_byte();
        test_full_frame();
        test_oversize();
        test_drop();
        test_accept_and_start();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
